// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory answering CPU MEM-stage loads/stores over req/ready/ack.
// Each access completes a fixed LATENCY cycles after acceptance; stall_o freezes the pipeline meanwhile.
// Build option DMEM_BYTE_MASK_EN: stores write only the bytes selected by be_i; otherwise full-word stores.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  be_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] data_o,
   output logic        err_o,
   output logic        stall_o
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [3:0]  be_q, be_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] data_q, data_d;
   logic [31:0] mem [DEPTH_WORDS];
   logic          accept, done, bad, wr_en;
   logic [AW-1:0] idx;
   logic [31:0]   bmask, wr_word;
   assign ready_o = (state_q == IDLE) & ~ack_q;
   assign ack_o   = ack_q;
   assign err_o   = err_q;
   assign data_o  = data_q;
   assign stall_o = req_i & ~ack_q;
   assign accept  = req_i & ready_o;
   assign done    = (state_q == BUSY) & (cnt_q == 4'd0);
   assign bad     = (addr_q[1:0] != 2'b00) | (addr_q[31:2] >= DEPTH_W);
   assign idx     = addr_q[AW+1:2];
   assign wr_en   = done & we_q & ~bad;
`ifdef DMEM_BYTE_MASK_EN
   assign bmask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
`else
   logic unused_be;
   assign unused_be = ^be_q;
   assign bmask     = '1;
`endif
   assign wr_word = (wdat_q & bmask) | (mem[idx] & ~bmask);
   // Next state: capture the request on acceptance, count down while busy, complete and pulse ack at zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = accept ? we_i   : we_q;
      addr_d  = accept ? addr_i : addr_q;
      wdat_d  = accept ? data_i : wdat_q;
      be_d    = accept ? be_i   : be_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = data_q;
      if (accept) begin
         state_d = BUSY;
         cnt_d   = 4'(LATENCY - 1);
      end
      if (state_q == BUSY) begin
         state_d = done ? IDLE : BUSY;
         cnt_d   = done ? 4'd0 : cnt_q - 4'd1;
         ack_d   = done;
         err_d   = done & bad;
         data_d  = !done ? data_q : bad ? 32'd0 : we_q ? data_q : mem[idx];
      end
   end
   // Control and response registers; reset aborts any outstanding access.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         be_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end
   // Storage array: written only by a completing aligned in-range store; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[idx] <= wr_word;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of dmem_responder against a queue/array reference model.
module tb_dmem_responder;
   localparam int LAT = 4;
   localparam int DW  = 1024;
`ifdef DMEM_BYTE_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = 4'hF;
   logic ready, ack, err, stall;
   logic [31:0] rdata;
   logic req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr1 = '0, wdata1 = '0;
   logic [3:0]  be1 = 4'hF;
   logic ready1, ack1, err1, stall1;
   logic [31:0] rdata1;
   int tests = 0, fails = 0;
   logic [31:0] model [int];
   logic [31:0] last_data = '0;
   always #5 clk = ~clk;
   dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata), .be_i(be),
      .ready_o(ready), .ack_o(ack), .data_o(rdata), .err_o(err), .stall_o(stall));
   dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .data_i(wdata1), .be_i(be1),
      .ready_o(ready1), .ack_o(ack1), .data_o(rdata1), .err_o(err1), .stall_o(stall1));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DW));
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (b[i] || !MASK) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction
   // called just after the acceptance edge; follows the access through to its ack cycle
   task automatic wait_ack(input string tag, input logic e_exp, input logic [31:0] d_exp);
      int lat;
      lat = 0;
      @(negedge clk);
      while (!ack && lat < 50) begin
         chk({tag, "_busy_stall"}, stall, 1);
         chk({tag, "_busy_ready"}, ready, 0);
         lat++;
         @(negedge clk);
      end
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_err"}, err, e_exp);
      chk({tag, "_data"}, rdata, d_exp);
      chk({tag, "_ack_stall"}, stall, 0);
      chk({tag, "_ack_ready"}, ready, 0);
   endtask
   task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int n;
      logic e;
      logic [31:0] exp;
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      #1;
      n = 0;
      while (!ready && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_ready"}, ready, 1);
      chk({tag, "_req_stall"}, stall, 1);
      e   = bad_addr(a);
      exp = e ? 32'd0 : w ? last_data : model[int'(a[31:2])];
      @(posedge clk);
      wait_ack(tag, e, exp);
      if (w && !e) model[int'(a[31:2])] = merge(model.exists(int'(a[31:2])) ? model[int'(a[31:2])] : 32'd0, d, b);
      last_data = exp;
      req = 1'b0;
      #1;
      chk({tag, "_idle_stall"}, stall, 0);
   endtask
   task automatic acc1(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d, input logic e_exp, input logic [31:0] d_exp);
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
      #1;
      chk({tag, "_ready"}, ready1, 1);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_busy_ack"}, ack1, 0);
      chk({tag, "_busy_stall"}, stall1, 1);
      chk({tag, "_busy_ready"}, ready1, 0);
      @(negedge clk);
      chk({tag, "_ack"}, ack1, 1);
      chk({tag, "_err"}, err1, e_exp);
      chk({tag, "_data"}, rdata1, d_exp);
      chk({tag, "_ack_ready"}, ready1, 0);
      req1 = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_back"}, ready1, 1);
      chk({tag, "_ack_gone"}, ack1, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   // Directed sequence followed by randomized traffic, all checked against the model.
   initial begin
      int gap;
      logic w;
      logic [31:0] a;
      logic [3:0]  b;
      repeat (2) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_ready", ready, 1);
      chk("rst_data", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_stall", stall, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", ready, 1);
      access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      access("ld10", 1'b0, 32'h10, 32'h0, 4'hF);
      chk("ld10_const", rdata, 32'hDEADBEEF);
      req = 1'b1; we = 1'b0; addr = 32'h10;
      @(negedge clk);
      chk("b2b_ready", ready, 1);
      @(posedge clk);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
         chk("b2b_stall", stall, (gap == LAT + 1) ? 0 : 1);
         chk("b2b_ack", ack, (gap == LAT + 1) ? 1 : 0);
         if (gap == LAT + 1) chk("b2b_data1", rdata, 32'hDEADBEEF);
      end while (!ready && gap < 50);
      chk("b2b_gap", gap, LAT + 2);
      @(posedge clk);
      wait_ack("b2b2", 1'b0, 32'hDEADBEEF);
      req = 1'b0;
      #1;
      chk("b2b_idle_stall", stall, 0);
      access("st30", 1'b1, 32'h30, 32'h11223344, 4'hF);
      access("st30b", 1'b1, 32'h30, 32'h0000AB00, 4'b0010);
      access("ld30", 1'b0, 32'h30, 32'h0, 4'hF);
      chk("ld30_const", rdata, MASK ? 32'h1122AB44 : 32'h0000AB00);
      access("st34z", 1'b1, 32'h34, 32'h55667788, 4'hF);
      access("st34n", 1'b1, 32'h34, 32'h99999999, 4'h0);
      access("ld34", 1'b0, 32'h34, 32'h0, 4'hF);
      access("st00", 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
      access("ld13", 1'b0, 32'h13, 32'h0, 4'hF);
      access("ldoor", 1'b0, DW * 4, 32'h0, 4'hF);
      access("st12", 1'b1, 32'h12, 32'h12121212, 4'hF);
      access("stoor", 1'b1, DW * 4, 32'h34343434, 4'hF);
      access("ld10b", 1'b0, 32'h10, 32'h0, 4'hF);
      chk("ld10b_const", rdata, 32'hDEADBEEF);
      access("ld00", 1'b0, 32'h0, 32'h0, 4'hF);
      access("st20", 1'b1, 32'h20, 32'h5, 4'hF);
      access("ld20a", 1'b0, 32'h20, 32'h0, 4'hF);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h99; be = 4'hF;
      @(negedge clk);
      chk("abort_ready", ready, 1);
      @(posedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ack", ack, 0);
      chk("abort_ready_rst", ready, 1);
      chk("abort_data", rdata, 0);
      req = 1'b0;
      repeat (2) begin @(negedge clk); chk("abort_hold_ack", ack, 0); end
      rst = 1'b0;
      repeat (LAT + 3) begin
         @(negedge clk);
         chk("abort_no_ack", ack, 0);
         chk("abort_ready_after", ready, 1);
      end
      last_data = 32'h0;
      access("ld20", 1'b0, 32'h20, 32'h0, 4'hF);
      chk("ld20_const", rdata, 32'h5);
      for (int i = 0; i < 16; i++) access("rinit", 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom_range(0, 1));
         b = 4'($urandom);
         a = 32'h100 + 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
         else if ($urandom_range(0, 7) == 0) a = DW * 4 + 32'($urandom_range(0, 1000) * 4);
         access("rand", w, a, $urandom, b);
      end
      acc1("l1_st", 1'b1, 32'h8, 32'hCAFE0001, 1'b0, 32'h0);
      acc1("l1_ld", 1'b0, 32'h8, 32'h0, 1'b0, 32'hCAFE0001);
      acc1("l1_oor", 1'b0, 32'h40, 32'h0, 1'b1, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

- Multi-cycle data-memory slave answering load/store requests from the CPU MEM stage over a req/ready/ack handshake.
- Holds a word-addressed storage array and completes each access a fixed LATENCY cycles after acceptance.
- Provides the stall source (`stall_o`) that freezes the pipeline while an access is outstanding.
- Replaces the single-cycle data memory when timing-realistic memory behaviour is required.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two; AW = clog2(DEPTH_WORDS).
- `LATENCY`, default 4: cycles from acceptance edge to completion edge; range 1..15.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset; asynchronous, active-high.
- `req_i`  input  1  request valid; held by the CPU until the cycle in which `ack_o` is high.
- `we_i`  input  1  1 = store, 0 = load.
- `addr_i`  input  32  byte address.
- `data_i`  input  32  store data.
- `be_i`  input  4  byte enables; bit n covers `data_i[8n+7:8n]`.
- `ready_o`  output  1  responder can accept a request this cycle.
- `ack_o`  output  1  one-cycle completion pulse.
- `data_o`  output  32  load result; registered; holds its value until the next ack.
- `err_o`  output  1  valid with `ack_o`; misaligned or out-of-range access.
- `stall_o`  output  1  combinational `req_i & ~ack_o`; drives the pipeline hazard freeze.

## Operation
- Two states: IDLE and BUSY, plus a 4-bit down-counter `cnt`.
- `ready_o` = (state == IDLE) & ~`ack_o`.
- Acceptance occurs at a rising edge where `req_i & ready_o`. At that edge:
  - `we_i`, `addr_i`, `data_i` and `be_i` are captured.
  - `cnt` loads LATENCY-1.
  - State goes to BUSY.
- BUSY: `cnt` decrements each edge. At the edge where `cnt == 0`, the access is performed and:
  - `ack_o` is set high for one cycle.
  - State returns to IDLE.
- Load: `data_o` is loaded with `mem[addr_i[AW+1:2]]` from the captured address.
- Store: the array word is updated and `data_o` is unchanged.
- Error: `err_o` is set when `addr_i[1:0] != 0` or `addr_i[31:2] >= DEPTH_WORDS`.
  - No array write occurs.
  - `data_o` is loaded with 0.
  - `ack_o` still pulses with the normal latency.
- `req_i` seen while state is BUSY or during the ack cycle is ignored; it is not queued.
- Reset (any time, including mid-access):
  - State returns to IDLE and `cnt` = 0.
  - `ack_o` = 0, `err_o` = 0, `data_o` = 0.
  - `ready_o` = 1 after reset deasserts.
  - A pending store is dropped.
  - The array contents are not cleared.

## Timing
- Request accepted at edge T: `ack_o` is high in the cycle after edge T+LATENCY.
- Store data is visible to a load accepted at any later edge.
- `ready_o` is low from after edge T through the ack cycle.
- The earliest next acceptance is edge T+LATENCY+2, so throughput is one access per LATENCY+2 cycles.
- `stall_o` is high in the acceptance cycle and every BUSY cycle, and low in the ack cycle, so the pipeline advances at the edge that ends the ack cycle.
- `stall_o` is low whenever `req_i` is low.

## Configuration
- `DMEM_BYTE_MASK_EN` defined:
  - A store writes only the bytes whose `be_i` bit is set.
  - A store with `be_i == 0` is a no-op but is still acked.
- `DMEM_BYTE_MASK_EN` undefined:
  - `be_i` is ignored and every store writes the full word.
  - Timing and handshake are identical in both builds.

## Test plan
- Reset, then store `0xDEADBEEF` to `0x10` and load `0x10`, with LATENCY=4.
  - Each `ack_o` appears 4 cycles after its acceptance edge.
  - The load returns `data_o = 0xDEADBEEF` and `err_o = 0`.
- Hold `req_i` high for two back-to-back loads.
  - The second acceptance occurs exactly LATENCY+2 edges after the first.
  - `stall_o` is low only in each ack cycle.
- Store with `be_i = 4'b0010` and `data_i = 0x0000AB00` over a word holding `0x11223344`, then load it.
  - With the macro: `0x1122AB44`.
  - Without the macro: `0x0000AB00`.
- Load from `0x13`, then load from `DEPTH_WORDS*4`.
  - Each gives `ack_o = 1`, `err_o = 1`, `data_o = 0` at the normal latency.
  - Neither changes the array.
- Assert `rst_i` two cycles into a store to `0x20` (old value `0x5`), then release it and load `0x20`.
  - During reset: `ack_o` stays 0, `ready_o` = 1 afterwards, no ack is emitted for the aborted store.
  - The load returns `0x5`.
- Run with LATENCY=1.
  - A request accepted at edge T acks in the cycle after edge T+1.
  - `ready_o` returns high one cycle later.
